// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// registers the returned word into the IF/ID stage with stall, redirect and fault handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1024,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] inst,
  output logic [31:0] addrIM,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  // Highest byte address at which a full 32-bit word still fits in memory.
  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  logic [31:0] pc;
  logic        pc_bad;
  logic        redirect_bad;

  assign addrIM       = pc;
  assign pc_bad       = (pc[1:0] != 2'b00) || (pc > LAST_PC);
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_PC);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_inst     <= NOP_INST;
      if_pc       <= 32'h0;
      if_pc4      <= 32'h0;
      if_valid    <= 1'b0;
      fault       <= 1'b0;
      fault_addr  <= 32'h0;
      fetch_count <= 32'h0;
    end else if (fault) begin
      // Sticky: only reset leaves this state, redirect and stall are ignored.
      if_valid <= 1'b0;
      if_inst  <= NOP_INST;
    end else if (redirect) begin
      if (redirect_bad) begin
        fault      <= 1'b1;
        fault_addr <= redirect_pc;
      end else begin
        pc <= redirect_pc;
      end
      if_valid <= 1'b0;
      if_inst  <= NOP_INST;
    end else if (!stall) begin
      if (pc_bad) begin
        fault      <= 1'b1;
        fault_addr <= pc;
        if_valid   <= 1'b0;
        if_inst    <= NOP_INST;
      end else begin
        if_inst     <= inst;
        if_pc       <= pc;
        if_pc4      <= pc + 32'd4;
        if_valid    <= 1'b1;
        pc          <= pc + 32'd4;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the byte-addressed instruction memory and drives its address.
- Holds the program counter (PC) and presents it on addrIM.
- Captures the returned 32-bit instruction into an IF/ID pipeline register for the decoder.
- Handles stall, branch/jump redirect with bubble insertion, alignment/range fault detection, and a retired-fetch counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 1024, instruction memory size in bytes. A fetch is legal only if pc+3 <= IMEM_BYTES-1.
- NOP_INST, 32'h0000_0013, instruction placed in if_inst on bubbles and reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID register.
- redirect  in  1  take redirect_pc next cycle; flush the IF/ID register.
- redirect_pc  in  32  branch/jump target byte address.
- inst  in  32  instruction returned by instruction memory for addrIM (combinational, same cycle).
- addrIM  out  32  byte address to instruction memory; always equals pc.
- if_inst  out  32  registered instruction for decode.
- if_pc  out  32  address of if_inst.
- if_pc4  out  32  if_pc + 4.
- if_valid  out  1  if_inst is a real fetched instruction.
- fault  out  1  sticky fetch fault.
- fault_addr  out  32  offending address that caused the fault.
- fetch_count  out  32  number of valid captures since reset; wraps at 2^32.

Behaviour:
- addrIM = pc, purely combinational. inst is sampled in the same cycle. The instruction at pc is visible on if_inst exactly 1 cycle later.
- Reset values (rst high at a clock edge):
  - pc = RESET_PC
  - if_inst = NOP_INST, if_pc = 0, if_pc4 = 0, if_valid = 0
  - fault = 0, fault_addr = 0, fetch_count = 0
  - rst overrides every other input, including mid-stall, mid-redirect and fault.
- Per-edge priority when not in reset: fault held > redirect > stall > advance.
- Fault held (fault = 1):
  - pc and fetch_count frozen; if_valid = 0; if_inst = NOP_INST.
  - redirect and stall are ignored. Only rst clears the fault.
- Redirect (redirect = 1), which overrides stall:
  - If redirect_pc[1:0] != 0 or redirect_pc > IMEM_BYTES-4: fault <= 1, fault_addr <= redirect_pc, pc unchanged.
  - Otherwise pc <= redirect_pc.
  - In both cases: if_valid <= 0, if_inst <= NOP_INST, and the in-flight inst is discarded. No count increment.
- Stall (stall = 1, redirect = 0): pc, if_* registers and fetch_count all hold their values.
- Advance (no stall, no redirect, no fault):
  - If pc > IMEM_BYTES-4: fault <= 1, fault_addr <= pc, if_valid <= 0, pc held.
  - Otherwise:
    - if_inst <= inst, if_pc <= pc, if_pc4 <= pc+4, if_valid <= 1
    - pc <= pc+4, fetch_count <= fetch_count+1
- Arithmetic:
  - All PC arithmetic is 32-bit modulo 2^32.
  - pc stays 4-byte aligned because RESET_PC must be aligned. A misaligned RESET_PC faults on the first advance edge (implementation checks pc[1:0] in the advance range test as well).
- Boundary cases:
  - Last legal fetch at pc = IMEM_BYTES-4 (1020) is captured normally. The following advance from pc = 1024 faults with fault_addr = 1024.
  - stall and redirect asserted together: redirect wins and a bubble is inserted.
  - Back-to-back redirects: each one is taken and if_valid stays 0 throughout.

Test Plan:
- Reset, then 4 free-running cycles with memory holding words A,B,C,D at 0,4,8,12 -> if_inst = A,B,C,D on cycles 1-4; if_pc = 0,4,8,12; if_pc4 = 4,8,12,16; if_valid = 1; fetch_count = 4.
- stall held 3 cycles at pc = 8 -> addrIM stays 8, if_inst/if_pc unchanged, fetch_count unchanged; on release, the word at 8 is captured next cycle.
- redirect = 1 with redirect_pc = 0x40 while stall = 1 -> next edge: pc = 0x40, if_valid = 0, if_inst = 0x00000013; following edge: if_inst = word at 0x40, if_pc = 0x40.
- redirect_pc = 0x42 -> fault = 1, fault_addr = 0x42, pc unchanged. Further redirect to 0x10 is ignored; if_valid stays 0.
- Run sequentially up to pc = 1020 -> word at 1020 captured; next edge fault = 1, fault_addr = 1024, fetch_count frozen.
- Assert rst during fault and during stall -> all outputs return to reset values at the next edge: pc = RESET_PC, fault = 0, fetch_count = 0.
